// File: rtl/dispense_sequencer.sv
// Beverage dispense sequencer: steps through the ingredient valves of the
// selected recipe, one phase per ingredient, each lasting a fixed number of ticks.
module dispense_sequencer #(
    parameter int T_AGUA   = 3,
    parameter int T_CAFE   = 2,
    parameter int T_LECHE  = 2,
    parameter int T_CHOC   = 2,
    parameter int T_AZUCAR = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] recipe,
    input  logic       sugar_en,
    input  logic       tick,
    input  logic       abort,
    output logic       agua,
    output logic       cafe,
    output logic       leche,
    output logic       chocolate,
    output logic       azucar,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] step,
    output logic [3:0] remaining
);

    // start, tick and abort are level qualifiers sampled on each rising edge;
    // there is no ready/acknowledge: start is accepted only in IDLE, abort only
    // in ingredient phases, tick only in ingredient phases, and abort beats both.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AGUA   = 3'd1,
        S_CAFE   = 3'd2,
        S_LECHE  = 3'd3,
        S_CHOC   = 3'd4,
        S_AZUCAR = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    localparam logic [3:0] LEN_AGUA   = 4'(T_AGUA);
    localparam logic [3:0] LEN_CAFE   = 4'(T_CAFE);
    localparam logic [3:0] LEN_LECHE  = 4'(T_LECHE);
    localparam logic [3:0] LEN_CHOC   = 4'(T_CHOC);
    localparam logic [3:0] LEN_AZUCAR = 4'(T_AZUCAR);

    state_t     state;
    logic [1:0] recipe_q;
    logic       sugar_q;

    function automatic logic [3:0] phase_len(input state_t s);
        logic [3:0] len;
        len = 4'd0;
        case (s)
            S_AGUA:   len = LEN_AGUA;
            S_CAFE:   len = LEN_CAFE;
            S_LECHE:  len = LEN_LECHE;
            S_CHOC:   len = LEN_CHOC;
            S_AZUCAR: len = LEN_AZUCAR;
            default:  len = 4'd0;
        endcase
        return len;
    endfunction

    // Valve order in the returned vector: agua, cafe, leche, chocolate, azucar.
    function automatic logic [4:0] valve_map(input state_t s);
        logic [4:0] v;
        v = 5'b00000;
        case (s)
            S_AGUA:   v = 5'b10000;
            S_CAFE:   v = 5'b01000;
            S_LECHE:  v = 5'b00100;
            S_CHOC:   v = 5'b00010;
            S_AZUCAR: v = 5'b00001;
            default:  v = 5'b00000;
        endcase
        return v;
    endfunction

    // Sugar is always the last ingredient; without it the last phase ends in FIN.
    function automatic state_t next_phase(input state_t cur, input logic [1:0] r,
                                          input logic s);
        state_t tail;
        state_t nxt;
        tail = s ? S_AZUCAR : S_FIN;
        nxt  = S_FIN;
        case (cur)
            S_AGUA:  nxt = (r == 2'd2) ? S_CHOC : S_CAFE;
            S_CAFE: begin
                case (r)
                    2'd1:    nxt = S_LECHE;
                    2'd3:    nxt = S_CHOC;
                    default: nxt = tail;
                endcase
            end
            S_CHOC:  nxt = (r == 2'd2) ? S_LECHE : tail;
            S_LECHE: nxt = tail;
            default: nxt = S_FIN;
        endcase
        return nxt;
    endfunction

    // Every state change goes through here so the outputs stay registered Moore
    // values of the state being entered.
    task automatic enter(input state_t s);
        state                                  <= s;
        step                                   <= s;
        remaining                              <= phase_len(s);
        {agua, cafe, leche, chocolate, azucar} <= valve_map(s);
        busy                                   <= (s != S_IDLE);
        done                                   <= (s == S_FIN);
    endtask

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            step      <= 3'd0;
            remaining <= 4'd0;
            agua      <= 1'b0;
            cafe      <= 1'b0;
            leche     <= 1'b0;
            chocolate <= 1'b0;
            azucar    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            recipe_q  <= 2'd0;
            sugar_q   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        recipe_q <= recipe;
                        sugar_q  <= sugar_en;
                        enter(S_AGUA);
                    end
                end
                S_FIN: begin
                    enter(S_IDLE);
                end
                S_AGUA, S_CAFE, S_LECHE, S_CHOC, S_AZUCAR: begin
                    if (abort) begin
                        enter(S_IDLE);
                        aborted <= 1'b1;
                    end else if (tick) begin
                        if (remaining == 4'd1) begin
                            enter(next_phase(state, recipe_q, sugar_q));
                        end else begin
                            remaining <= remaining - 4'd1;
                        end
                    end
                end
                default: begin
                    enter(S_IDLE);
                end
            endcase
        end
    end

endmodule
